// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: width and starvation
// defaults, FSM state encoding and the grant encoding.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int STARVE_LIMIT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // Counter width able to hold 0..limit, never narrower than one bit.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory
// bus. D has priority, but I is forced through after STARVE_LIMIT consecutive
// D grants that happened while I was waiting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);

  localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t              state;
  state_t              next_state;
  gnt_t                gnt;
  logic [CNT_W-1:0]    starve_cnt;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                any_req;
  logic                pick_d;

  assign any_req = i_req | d_req;
  // D wins unless I has already been passed over the maximum number of times.
  assign pick_d  = d_req & (~i_req | (starve_cnt != CNT_MAX));

  // The bus is only driven by this block during the write cycle.
  assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = (pick_d && d_we) ? WRITE : RD_ADDR;
      RD_ADDR: next_state = RD_DATA;
      RD_DATA: next_state = DONE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and acks decoded from the current state and the latched grant.
  always_comb begin
    readM  = 1'b0;
    writeM = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    case (state)
      RD_ADDR: readM  = 1'b1;
      RD_DATA: readM  = 1'b1;
      WRITE:   writeM = 1'b1;
      DONE: begin
        i_ack = (gnt == GNT_I);
        d_ack = (gnt == GNT_D);
      end
      default: ;
    endcase
  end

  // Grant-time capture of address/wdata, starvation tracking, read capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt        <= GNT_I;
      address    <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        if (pick_d) begin
          gnt     <= GNT_D;
          address <= d_addr;
          wdata_q <= d_wdata;
          if (!i_req) begin
            starve_cnt <= '0;
          end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end else begin
          gnt        <= GNT_I;
          address    <= i_addr;
          starve_cnt <= '0;
        end
      end
      if (state == RD_DATA) begin
        if (gnt == GNT_I) begin
          i_rdata <= data;
        end else begin
          d_rdata <= data;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the data and address width.
REQ-002 Parameter STARVE_LIMIT, default 2, SHALL set the maximum consecutive D grants allowed while i_req is pending.
REQ-003 clk, input, 1: the block SHALL sample all inputs and update all state on the rising edge of clk.
REQ-004 reset_n, input, 1: reset SHALL be synchronous and active-low.
REQ-005 i_req, input, 1: the instruction-fetch port SHALL assert this to request a read.
REQ-006 i_addr, input, WORD_SIZE: this SHALL carry the fetch address, held stable while i_req is high.
REQ-007 i_ack, output, 1: the block SHALL pulse this for one cycle when the fetch completes.
REQ-008 i_rdata, output, WORD_SIZE: this SHALL carry the fetched word and SHALL be valid while i_ack is high.
REQ-009 d_req, input, 1: the data port SHALL assert this to request an access.
REQ-010 d_we, input, 1: the data port SHALL set this to 1 for a write and 0 for a read.
REQ-011 d_addr, input, WORD_SIZE: this SHALL carry the data-access address, held stable while d_req is high.
REQ-012 d_wdata, input, WORD_SIZE: this SHALL carry the write data, held stable while d_req is high.
REQ-013 d_ack, output, 1: the block SHALL pulse this for one cycle when the data access completes.
REQ-014 d_rdata, output, WORD_SIZE: this SHALL carry the read word and SHALL be valid while d_ack is high after a read.
REQ-015 readM, output, 1: this SHALL be the read strobe to the shared memory.
REQ-016 writeM, output, 1: this SHALL be the write strobe to the shared memory.
REQ-017 address, output, WORD_SIZE: this SHALL be the memory address, registered at grant.
REQ-018 data, inout, WORD_SIZE: this SHALL be the shared memory data bus.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WRITE and DONE.
REQ-020 In IDLE with any request pending, the block SHALL grant one port, register its address and write data, and move to RD_ADDR for a read or to WRITE for a write.
REQ-021 The I port SHALL always be treated as a read.
REQ-022 In RD_ADDR, readM SHALL be 1 and address SHALL be held, and the FSM SHALL move to RD_DATA.
REQ-023 In RD_DATA, readM SHALL remain 1, the block SHALL capture data into the granted port's rdata register, and the FSM SHALL move to DONE.
REQ-024 In WRITE, writeM SHALL be 1, data SHALL be driven with the registered wdata, and the FSM SHALL move to DONE.
REQ-025 In DONE, the block SHALL hold i_ack or d_ack high for exactly one cycle, SHALL ignore all requests, and SHALL return to IDLE.
REQ-026 Read latency SHALL be 3 cycles (req sampled in cycle 0, ack in cycle 3), and write latency SHALL be 2 cycles.
REQ-027 Each requester SHALL deassert req in the cycle after its ack, and a req still high in IDLE SHALL start a new transaction.
REQ-028 On simultaneous requests, D SHALL win unless starve_cnt equals STARVE_LIMIT, in which case I SHALL win.
REQ-029 starve_cnt SHALL increment when D is granted while i_req is high, SHALL clear when I is granted, SHALL clear when D is granted while i_req is low, and SHALL saturate at STARVE_LIMIT.
REQ-030 readM and writeM SHALL never both be 1.
REQ-031 data SHALL be high-Z whenever writeM is 0.
REQ-032 address SHALL pass all WORD_SIZE bits through unmodified, with no range check.
REQ-033 rdata registers SHALL hold their last value until they are overwritten.

Reset
REQ-034 While reset_n is 0 at a clock edge, the FSM SHALL go to IDLE, starve_cnt SHALL clear to 0, and readM, writeM, i_ack and d_ack SHALL be 0.
REQ-035 While reset_n is 0, address, i_rdata and d_rdata SHALL be 0x0000 and data SHALL be high-Z.
REQ-036 A reset in any state SHALL abort the transaction in progress without an ack, and the requester SHALL re-issue it.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the WORD_SIZE and STARVE_LIMIT defaults, and the grant encoding (GNT_I, GNT_D).
REQ-038 The block SHALL be a single module with no sub-module, with the tristate driver on data inside mem_port_arbiter.

Verification
REQ-039 Fetch after memory reset: i_req=1, i_addr=0x0000 -> i_ack in cycle 3 with i_rdata=0x9023.
REQ-040 Write then read: D write 0xBEEF to 0x0005 -> d_ack in cycle 2; then D read 0x0005 -> d_rdata=0xBEEF.
REQ-041 Simultaneous requests: i_addr=0x0001 and D read of 0x0002 -> d_ack first with d_rdata=0xFFFF, then i_ack with i_rdata=0x0001.
REQ-042 Starvation: d_req held continuously with i_req=1 -> the third grant goes to I, then D resumes.
REQ-043 Reset mid-read: reset_n=0 in RD_DATA -> no ack, readM=0 on the next cycle, FSM in IDLE.
REQ-044 Bus assertions over all tests: readM and writeM never both 1, and data is high-Z whenever writeM=0.
